dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Data-memory load/store unit directly downstream of the CPU core's memory port.
- Consumes the core's address, store data, write enable and DMType. Owns a word-organised synchronous data RAM.
- Performs byte-lane store masking and load sign/zero extension.
- Returns results through a valid/ready response handshake so a pipelined core can stall on it.

Parameters:
- ADDR_W, 10, word-index width; RAM holds 2^ADDR_W 32-bit words.
- RESET_CLR, 0, reserved; RAM contents are never cleared by reset; must be 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_dmtype  input  3  000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  32  load result; 0 for stores.
- rsp_err  output  1  misalignment flag; constant 0 unless the macro is defined.

Behaviour:
- Reset (rst=0, async), all outputs registered:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
  - Any in-flight request is dropped. RAM contents are preserved.
  - req_ready rises at the first clk edge after rst returns to 1.
- States:
  - IDLE: req_ready=1.
  - LOAD: RAM word captured, formatting pending.
  - RESP: rsp_valid=1.
- Accept: req_valid&&req_ready at edge E0; req_ready drops to 0 at E0.
- Store at E0: byte lanes written in the same edge; state->RESP, so rsp_valid=1 one cycle after accept, rsp_rdata=0.
- Load at E0: RAM word read into rd_word; state->LOAD. At E1: formatted result registered into rsp_rdata, rsp_valid=1, state->RESP. Latency from accept to rsp_valid is 2 cycles.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid->0, state->IDLE, req_ready->1 at that edge.
  - No request is accepted in the same cycle a response completes.
- Word index = req_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2^ADDR_W.
- Store lanes:
  - word: all 4 bytes.
  - half: addr[1]=0 -> lanes 1:0, else lanes 3:2; data = wdata[15:0].
  - byte: lane addr[1:0]; data = wdata[7:0].
- Load extraction uses the same lane selection:
  - half: bit 15 replicated into 31:16.
  - half-unsigned: zero-extend.
  - byte: bit 7 replicated into 31:8.
  - byte-unsigned: zero-extend.
- DMType codes 101-111 are treated as word for both loads and stores.
- Alignment without the macro:
  - word ignores addr[1:0]; half ignores addr[0].
  - No error is raised.
- req_* inputs are ignored outside IDLE; the unit does not latch them.

Optional Feature:
- Macro DM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means word with addr[1:0]!=0, or half/half-unsigned with addr[0]=1.
  - A misaligned store writes no bytes; a misaligned load returns rsp_rdata=0.
  - Either case gives rsp_err=1 alongside rsp_valid; rsp_err clears with the handshake.
  - Latencies are unchanged.
- Undefined: rsp_err tied to 0, alignment handling as above.

Test Plan:
- Reset: hold rst=0 with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0. Release -> req_ready=1 after 1 edge; assert rst=0 during LOAD -> rsp_valid stays 0, state IDLE.
- sw 0x12345678 @0x10 -> rsp_valid 1 cycle after accept, rsp_rdata=0. Then lw @0x10 -> rsp_valid 2 cycles after accept, rsp_rdata=0x12345678.
- sb 0xAB @0x11 -> lw @0x10=0x1234AB78; lb @0x11=0xFFFFFFAB; lbu @0x11=0x000000AB.
- sh 0x8001 @0x12 -> lw @0x10=0x8001AB78; lh @0x12=0xFFFF8001; lhu @0x12=0x00008001. With ADDR_W=10, lw @0x1010 also returns 0x8001AB78 (alias).
- Backpressure: lw with rsp_ready=0 for 3 cycles -> rsp_valid=1 and rsp_rdata held constant, req_ready=0. rsp_ready=1 -> rsp_valid=0 and req_ready=1 next cycle.
- Misalign: lw @0x12.
  - Without macro: 0x8001AB78, rsp_err=0.
  - With DM_MISALIGN_TRAP_EN: rsp_rdata=0, rsp_err=1. sh 0xFFFF @0x13 gives rsp_err=1 and lw @0x10 still 0x8001AB78.

Source files
------------

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: word-organised synchronous RAM with byte-lane
// store masking, load sign/zero extension and a valid/ready response port.
// Optional misalignment trapping is enabled by defining DM_MISALIGN_TRAP_EN.
module dmem_lsu #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned RESET_CLR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dmtype,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StResp} state_e;
    typedef enum logic [2:0] {FmtWord, FmtHalf, FmtHalfU, FmtByte, FmtByteU} fmt_e;

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    fmt_e                ld_fmt_q, ld_fmt_d;
    logic [1:0]          ld_lane_q, ld_lane_d;
    logic                ld_err_q, ld_err_d;

    logic [31:0]         mem_q [2**ADDR_W];
    logic [31:0]         rd_word_q;

    fmt_e                req_fmt;
    logic [ADDR_W-1:0]   idx;
    logic                accept;
    logic                misalign;
    logic [3:0]          be;
    logic [31:0]         wdata_rep;
    logic                ram_we;
    logic                ram_re;
    logic [31:0]         ld_result;

    // Upper address bits alias by design; RESET_CLR is reserved.
    logic unused_cfg;
    assign unused_cfg = (^req_addr[31:ADDR_W+2]) ^ (RESET_CLR != 0);

    assign idx    = req_addr[ADDR_W+1:2];
    assign accept = req_valid && req_ready_q;
    assign ram_we = accept && req_we && !misalign;
    assign ram_re = accept && !req_we;

    // Decode DMType; undefined codes behave as word accesses.
    always_comb begin
        case (req_dmtype)
            3'b001:  req_fmt = FmtHalf;
            3'b010:  req_fmt = FmtHalfU;
            3'b011:  req_fmt = FmtByte;
            3'b100:  req_fmt = FmtByteU;
            default: req_fmt = FmtWord;
        endcase
    end

`ifdef DM_MISALIGN_TRAP_EN
    assign misalign = ((req_fmt == FmtWord) && (req_addr[1:0] != 2'b00)) ||
                      (((req_fmt == FmtHalf) || (req_fmt == FmtHalfU)) && req_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
        case (req_fmt)
            FmtHalf, FmtHalfU: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            FmtByte, FmtByteU: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // RAM array and read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            rd_word_q <= mem_q[idx];
        end
    end

    // Extract and extend the loaded lane captured at accept time.
    always_comb begin
        logic [15:0] half;
        logic [7:0]  byte_v;
        half   = ld_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        byte_v = rd_word_q[{ld_lane_q, 3'b000} +: 8];
        case (ld_fmt_q)
            FmtHalf:  ld_result = {{16{half[15]}}, half};
            FmtHalfU: ld_result = {16'h0000, half};
            FmtByte:  ld_result = {{24{byte_v[7]}}, byte_v};
            FmtByteU: ld_result = {24'h000000, byte_v};
            default:  ld_result = rd_word_q;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ld_fmt_d    = ld_fmt_q;
        ld_lane_d   = ld_lane_q;
        ld_err_d    = ld_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (req_we) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = misalign;
                    end else begin
                        state_d   = StLoad;
                        ld_fmt_d  = req_fmt;
                        ld_lane_d = req_addr[1:0];
                        ld_err_d  = misalign;
                    end
                end else begin
                    // Covers the first edge after reset release.
                    req_ready_d = 1'b1;
                end
            end
            StLoad: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_err_q ? 32'h0 : ld_result;
                rsp_err_d   = ld_err_q;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            ld_fmt_q    <= FmtWord;
            ld_lane_q   <= 2'b00;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ld_fmt_q    <= ld_fmt_d;
            ld_lane_q   <= ld_lane_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
